ps2_scan_receiver: RTL and testbench
====================================

Name: ps2_scan_receiver

Overview:
Parametrised PS/2 keyboard receiver that replaces the fixed three-frame capture FSM. It filters the raw PS2_CLK and PS2_DATA lines and deframes 11-bit frames of any length or sequence. A decoder folds E0/F0 prefixes into single make/break events and queues them in a valid/ready FIFO. Sits between the board PS/2 pins and the LCD/text data controller.

Parameters:
FILTER_DEPTH, 8, number of consecutive equal samples needed to change a filtered line level (2..16)
FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..64)
TIMEOUT_CYCLES, 100000, clk cycles without a filtered PS2_CLK falling edge before an in-progress frame is aborted

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
PS2_CLK  in  1  raw keyboard clock, asynchronous
PS2_DATA  in  1  raw keyboard data, asynchronous
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts the head event when ev_valid && ev_ready
ev_code  out  8  scan code of the head event
ev_ext  out  1  head event was E0-prefixed
ev_break  out  1  head event was F0-prefixed (key release)
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of queued events
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow
frame_err  out  1  one-cycle pulse on a framing, parity or timeout error

Behaviour:
- Reset: one clock, synchronous, active-low. All outputs are 0, the FIFO is empty, the filtered lines are 1, and both FSMs are in IDLE. A reset mid-frame discards the partial frame and the decoder prefix flags.
- Input conditioning:
  - Each raw line passes through a 2-flop synchroniser (reset value 1), then a FILTER_DEPTH shift register.
  - The filtered level goes to 1 when all taps are 1 and to 0 when all taps are 0; otherwise it holds.
  - A falling edge is the filtered clock going from 1 to 0, registered as a one-cycle fall pulse.
- Frame FSM:
  - States: IDLE, RECV, CHECK.
  - IDLE -> RECV on fall while filtered data is 0 (start bit); bit_cnt=1.
  - RECV: on each fall, shift in filtered data LSB-first and increment bit_cnt. After the 11th bit -> CHECK.
  - CHECK (one cycle): the frame is valid if start=0, stop=1 and the parity rule below holds. Valid -> byte_valid pulse with the 8 data bits. Invalid -> frame_err pulse. Both cases -> IDLE.
  - Timeout: in RECV, a counter that resets on every fall reaching TIMEOUT_CYCLES-1 triggers frame_err and a return to IDLE.
  - A fall in IDLE with data=1 is ignored.
- Decoder (prefix flags ext, brk):
  - byte E0 sets ext.
  - byte F0 sets brk.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - A frame error clears both flags.
- Latency: with the 11th fall sampled at edge N, CHECK is at N+1, the push at N+2, and ev_valid is high after edge N+2 when the FIFO was empty.
- FIFO:
  - Synchronous, first-word fall-through outputs.
  - Push while full with no pop in the same cycle: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both happen and the count is unchanged.
  - Pop while empty is ignored.
  - ovf_clr clears overflow. A drop in the same cycle wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is 0..FIFO_DEPTH.

Optional Feature:
PS2_PARITY_CHECK_EN:
- Defined: the frame is valid only if the 8 data bits plus the parity bit hold an odd number of ones; a mismatch gives frame_err and no byte.
- Undefined: the parity bit is captured but ignored, and only start/stop bits are checked.

Test Plan:
- Frame 0x1C (parity 0), ev_ready=1 -> one event: code=1C, ext=0, break=0; fifo_count returns to 0.
- Sequence E0,F0,75 with ev_ready=0 -> fifo_count=1, event code=75, ext=1, break=1; no events for the prefix bytes.
- Frame with stop bit 0 -> frame_err pulse, no event; the next good frame 0x1C is received normally.
- Frame stopped after 5 bits -> frame_err exactly TIMEOUT_CYCLES after the last fall; a following frame is decoded correctly.
- FIFO_DEPTH+2 make codes with ev_ready=0 -> fifo_count=FIFO_DEPTH, overflow=1, the first FIFO_DEPTH codes pop in order; ovf_clr -> overflow=0.
- Glitches on PS2_CLK shorter than FILTER_DEPTH cycles mid-frame -> no extra bits; rst low mid-frame -> all outputs 0 and the next frame is decoded; with PS2_PARITY_CHECK_EN, bad parity -> frame_err and no event.

Source files
------------

// File: rtl/ps2_scan_receiver_if.sv
// rtl/ps2_scan_receiver_if.sv - scan-code event stream between the PS/2 receiver and its consumer
interface ps2_scan_receiver_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 line filter, frame deframer, E0/F0 decoder and event FIFO
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scan_receiver #(
  parameter int FILTER_DEPTH   = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              PS2_CLK,
  input  logic                              PS2_DATA,
  ps2_scan_receiver_if.master               ev,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  input  logic                              ovf_clr,
  output logic                              frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [1:0]              clk_sync, data_sync;
  logic [FILTER_DEPTH-1:0] clk_taps, data_taps;
  logic                    clk_filt, data_filt, fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_taps  <= '1;
      data_taps <= '1;
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
      clk_taps  <= {clk_taps[FILTER_DEPTH-2:0], clk_sync[1]};
      data_taps <= {data_taps[FILTER_DEPTH-2:0], data_sync[1]};
      if (&clk_taps) clk_filt <= 1'b1;
      else if (~|clk_taps) clk_filt <= 1'b0;
      if (&data_taps) data_filt <= 1'b1;
      else if (~|data_taps) data_filt <= 1'b0;
      // pulse on the same edge the filtered level drops
      fall <= clk_filt & ~|clk_taps;
    end
  end

  state_t        state, state_nx;
  logic [3:0]    bit_cnt, bit_cnt_nx;
  logic [10:0]   frame, frame_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic          frame_ok, byte_ok, err_c;

  // frame[0]=start, frame[8:1]=data, frame[9]=parity, frame[10]=stop
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = !frame[0] && frame[10] && (^frame[9:1]);
`else
    frame_ok = !frame[0] && frame[10];
`endif
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    frame_nx   = frame;
    tmo_nx     = tmo;
    byte_ok    = 1'b0;
    err_c      = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !data_filt) begin
          state_nx   = RECV;
          bit_cnt_nx = 4'd1;
          frame_nx   = {data_filt, 10'b0};
          tmo_nx     = '0;
        end
      end
      RECV: begin
        if (fall) begin
          frame_nx   = {data_filt, frame[10:1]};
          bit_cnt_nx = bit_cnt + 4'd1;
          tmo_nx     = '0;
          if (bit_cnt == 4'd10) state_nx = CHECK;
        end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          err_c    = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_nx = tmo + TW'(1);
        end
      end
      CHECK: begin
        byte_ok  = frame_ok;
        err_c    = !frame_ok;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  logic       byte_valid;
  logic [7:0] byte_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      frame      <= '0;
      tmo        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      frame      <= frame_nx;
      tmo        <= tmo_nx;
      byte_valid <= byte_ok;
      byte_data  <= frame[8:1];
      frame_err  <= err_c;
    end
  end

  logic ext_flag, brk_flag, push;

  assign push = byte_valid && (byte_data != 8'hE0) && (byte_data != 8'hF0);

  always_ff @(posedge clk) begin
    if (!rst || frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == 8'hE0) ext_flag <= 1'b1;
      else if (byte_data == 8'hF0) brk_flag <= 1'b1;
      else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en, drop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = ev.ev_valid && ev.ev_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ext_flag, brk_flag, byte_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop) count <= count + CW'(1);
      else if (pop && !wr_en) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // head fields read as zero when empty so outputs stay clean after reset
  assign ev.ev_valid = (count != '0);
  assign {ev.ev_ext, ev.ev_break, ev.ev_code} = ev.ev_valid ? mem[rd_ptr] : 10'd0;
  assign fifo_count  = count;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb/tb_ps2_scan_receiver.sv - randomized scoreboard bench for ps2_scan_receiver
module tb_ps2_scan_receiver;
  localparam int FD    = 8;
  localparam int DEPTH = 4;
  localparam int T     = 300;
  localparam int HALF  = 20;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic ovf_clr = 1'b0;
  logic overflow, frame_err;
  logic [CW-1:0] fifo_count;

  ps2_scan_receiver_if ev_if ();

  ps2_scan_receiver #(.FILTER_DEPTH(FD), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .ev(ev_if),
    .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_err = 0;
  int err_cyc = 0;
  int last_fall_cyc = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_e;
  bit m_ext, m_brk, m_ovf;
  bit rnd_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every accepted event is popped against the scoreboard
  always @(negedge clk) begin
    if (rst && ev_if.ev_valid && ev_if.ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got %h expected none", {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code});
      end else begin
        exp_e = exp_q.pop_front();
        if ({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code} !== exp_e) begin
          errors++;
          $display("FAIL event {ext,brk,code}: got %h expected %h",
                   {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, exp_e);
        end
      end
    end
    if (rst && frame_err) begin
      err_seen++;
      err_cyc = cyc;
    end
  end

  initial begin
    ev_if.ev_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rnd_mode) ev_if.ev_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int nbits, input bit bad_stop,
                      input bit bad_par, input bit glitch);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 4) begin
        wait_cyc(6);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 9);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  // reference model: frame validity and prefix folding from the protocol rules
  task automatic issue(input logic [7:0] b, input int nbits, input bit bad_stop,
                       input bit bad_par, input bit glitch);
    bit ok;
    ok = (nbits == 11) && !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && !bad_par;
`endif
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      exp_err++;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    send(b, nbits, bad_stop, bad_par, glitch);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      wait_cyc(1);
      k++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int k, e0;
    logic [7:0] b;
    int r;
    wait_cyc(3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", ev_if.ev_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, 0);

    ev_if.ev_ready = 1'b1;
    issue(8'h1C, 11, 0, 0, 0);
    check("make_count", fifo_count, 0);

    ev_if.ev_ready = 1'b0;
    issue(8'hE0, 11, 0, 0, 0);
    issue(8'hF0, 11, 0, 0, 0);
    issue(8'h75, 11, 0, 0, 0);
    check("prefix_count", fifo_count, 1);
    ev_if.ev_ready = 1'b1;
    drain();

    issue(8'h1C, 11, 1, 0, 0);
    check("stop_err", err_seen, exp_err);
    issue(8'h1C, 11, 0, 0, 0);

    e0 = err_seen;
    issue(8'h2A, 5, 0, 0, 0);
    k = 0;
    while (err_seen == e0 && k < T + 200) begin
      wait_cyc(1);
      k++;
    end
    check("timeout_seen", err_seen, e0 + 1);
    // raw edge reaches the FSM after 2 sync + FD filter + 2 register stages
    check("timeout_delay", err_cyc - last_fall_cyc, T + FD + 4);
    issue(8'h5A, 11, 0, 0, 0);

    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) issue(8'h10 + 8'(i), 11, 0, 0, 0);
    check("ovf_count", fifo_count, DEPTH);
    check("ovf_set", overflow, m_ovf);
    ev_if.ev_ready = 1'b1;
    drain();
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    check("ovf_clr", overflow, m_ovf);

    issue(8'h3C, 11, 0, 0, 1);
    issue(8'h1C, 11, 0, 1, 0);
    check("glitch_par_err", err_seen, exp_err);

    ev_if.ev_ready = 1'b0;
    issue(8'h4B, 11, 0, 0, 0);
    issue(8'hE0, 11, 0, 0, 0);
    send(8'h33, 5, 0, 0, 0);
    rst = 1'b0;
    wait_cyc(1);
    rst = 1'b1;
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_valid", ev_if.ev_valid, 0);
    check("mid_rst_err", frame_err, 0);
    ev_if.ev_ready = 1'b1;
    issue(8'h1C, 11, 0, 0, 0);
    drain();

    rnd_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom);
      if (r < 2) b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      issue(b, 11, r == 3, r == 4, r == 5);
    end
    rnd_mode = 1'b0;
    #1 ev_if.ev_ready = 1'b1;
    wait_cyc(100);
    check("final_queue", exp_q.size(), 0);
    check("final_count", fifo_count, 0);
    check("final_errs", err_seen, exp_err);
    check("final_ovf", overflow, m_ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
